// File: rtl/inst_decode.sv
// Purpose : decode stage of the 16-bit RISC core; splits an instruction into ALU op, register selects, immediate and write enable.
// Latency : 1 cycle; every output is registered and loads on the rising I_CLK edge that sees I_EN=1.
// Backpress: none. With I_EN=0 all outputs hold their last decoded values.
//
// Ports
//   I_CLK    in   1   clock, rising edge active
//   I_RSTN   in   1   asynchronous active-low reset; clears every output
//   I_EN     in   1   decode enable
//   I_INST   in   16  instruction word {opcode, rD, rA, rB}
//   O_ALUOP  out  5   {imm_sel, opcode}
//   O_SELA   out  4   source register A select (rA)
//   O_SELB   out  4   source register B select (rB)
//   O_SELD   out  4   destination register select (rD)
//   O_IMME   out  16  immediate operand
//   O_REGWE  out  1   register-file write enable
//
// Build option
//   INST_DECODE_R0_PROTECT_EN : when defined, R0 is read-only, so O_REGWE is
//   forced low for any instruction whose rD field is 0.

module inst_decode (
  input  logic        I_CLK,
  input  logic        I_RSTN,
  input  logic        I_EN,
  input  logic [15:0] I_INST,
  output logic [4:0]  O_ALUOP,
  output logic [3:0]  O_SELA,
  output logic [3:0]  O_SELB,
  output logic [3:0]  O_SELD,
  output logic [15:0] O_IMME,
  output logic        O_REGWE
);

  // Opcodes whose decode differs from the plain register-register default.
  localparam logic [3:0] OP_LOADI  = 4'h8;
  localparam logic [3:0] OP_LOADHI = 4'h9;
  localparam logic [3:0] OP_ADDI   = 4'hA;
  localparam logic [3:0] OP_JUMP   = 4'hC;
  localparam logic [3:0] OP_BRANCH = 4'hD;
  localparam logic [3:0] OP_STORE  = 4'hE;

  typedef struct packed {
    logic [4:0]  aluop;
    logic [3:0]  sela;
    logic [3:0]  selb;
    logic [3:0]  seld;
    logic [15:0] imme;
    logic        regwe;
  } dec_t;

  logic [3:0] opcode;
  logic [3:0] rd;
  logic [3:0] ra;
  logic [3:0] rb;

  assign opcode = I_INST[15:12];
  assign rd     = I_INST[11:8];
  assign ra     = I_INST[7:4];
  assign rb     = I_INST[3:0];

  dec_t dec_nxt;
  dec_t dec_q;
  logic table_we;

  // Register selects pass straight through for every opcode; only the
  // immediate, the imm_sel bit and the write enable depend on the opcode.
  always_comb begin
    dec_nxt       = '0;
    table_we      = 1'b1;
    dec_nxt.seld  = rd;
    dec_nxt.sela  = ra;
    dec_nxt.selb  = rb;
    dec_nxt.aluop = {1'b0, opcode};

    case (opcode)
      OP_LOADI: begin
        dec_nxt.aluop[4] = 1'b1;
        dec_nxt.imme     = {8'h00, I_INST[7:0]};
      end
      OP_LOADHI: begin
        dec_nxt.aluop[4] = 1'b1;
        dec_nxt.imme     = {I_INST[7:0], 8'h00};
      end
      OP_ADDI: begin
        // Only the rB nibble carries the immediate; rA still selects the source.
        dec_nxt.aluop[4] = 1'b1;
        dec_nxt.imme     = {{12{I_INST[3]}}, I_INST[3:0]};
      end
      OP_JUMP: begin
        dec_nxt.aluop[4] = 1'b1;
        dec_nxt.imme     = {{8{I_INST[7]}}, I_INST[7:0]};
        table_we         = 1'b0;
      end
      OP_BRANCH, OP_STORE: begin
        table_we = 1'b0;
      end
      default: begin
        // ALU ops, CMP (writes flags word to rD) and LOAD: no immediate, write rD.
      end
    endcase

`ifdef INST_DECODE_R0_PROTECT_EN
    dec_nxt.regwe = table_we & (rd != 4'h0);
`else
    dec_nxt.regwe = table_we;
`endif
  end

  // Async clear wins over enable; a reset released on an edge leaves that
  // edge without effect, so the first load happens on the following edge.
  always_ff @(posedge I_CLK or negedge I_RSTN) begin
    if (!I_RSTN) begin
      dec_q <= '0;
    end else if (I_EN) begin
      dec_q <= dec_nxt;
    end
  end

  assign O_ALUOP = dec_q.aluop;
  assign O_SELA  = dec_q.sela;
  assign O_SELB  = dec_q.selb;
  assign O_SELD  = dec_q.seld;
  assign O_IMME  = dec_q.imme;
  assign O_REGWE = dec_q.regwe;

endmodule

// File: tb/tb_inst_decode.sv
// Purpose : scoreboard bench for inst_decode; driver pushes expected register contents, monitor pops and compares.
// Latency : expectations are checked 1 ns after the rising edge that should have loaded them.
// Backpress: none; the driver issues one stimulus per clock.

module tb_inst_decode;

  typedef struct packed {
    logic [4:0]  aluop;
    logic [3:0]  sela;
    logic [3:0]  selb;
    logic [3:0]  seld;
    logic [15:0] imme;
    logic        regwe;
  } out_t;

  logic        I_CLK;
  logic        I_RSTN;
  logic        I_EN;
  logic [15:0] I_INST;
  logic [4:0]  O_ALUOP;
  logic [3:0]  O_SELA;
  logic [3:0]  O_SELB;
  logic [3:0]  O_SELD;
  logic [15:0] O_IMME;
  logic        O_REGWE;

  int   n_checks = 0;
  int   n_errors = 0;
  out_t exp_q[$];
  out_t model_state = '0;
  bit   r0_protect;

  inst_decode dut (
    .I_CLK   (I_CLK),
    .I_RSTN  (I_RSTN),
    .I_EN    (I_EN),
    .I_INST  (I_INST),
    .O_ALUOP (O_ALUOP),
    .O_SELA  (O_SELA),
    .O_SELB  (O_SELB),
    .O_SELD  (O_SELD),
    .O_IMME  (O_IMME),
    .O_REGWE (O_REGWE)
  );

  initial I_CLK = 1'b0;
  always #5 I_CLK = ~I_CLK;

  function automatic out_t actual();
    out_t a;
    a = {O_ALUOP, O_SELA, O_SELB, O_SELD, O_IMME, O_REGWE};
    return a;
  endfunction

  function automatic out_t mk(input logic [4:0] aluop, input logic [3:0] seld,
                              input logic [3:0] sela, input logic [3:0] selb,
                              input logic [15:0] imme, input logic regwe);
    out_t r;
    r.aluop = aluop; r.seld = seld; r.sela = sela; r.selb = selb;
    r.imme = imme; r.regwe = regwe;
    return r;
  endfunction

  // Reference decode written from the opcode table with integer arithmetic.
  function automatic out_t model(input logic [15:0] inst);
    out_t r;
    int   op;
    int   lo8;
    int   lo4;
    int   imm;
    bit   we;
    bit   isel;
    op  = int'(inst) / 4096;
    lo8 = int'(inst) % 256;
    lo4 = int'(inst) % 16;
    imm = 0;
    case (op)
      8:  imm = lo8;
      9:  imm = lo8 * 256;
      10: imm = (lo4 >= 8) ? lo4 - 16 : lo4;
      12: imm = (lo8 >= 128) ? lo8 - 256 : lo8;
      default: imm = 0;
    endcase
    isel = (op == 8) || (op == 9) || (op == 10) || (op == 12);
    we   = !((op == 12) || (op == 13) || (op == 14));
    if (r0_protect && ((int'(inst) / 256) % 16 == 0)) we = 1'b0;
    r.aluop = {isel, 4'(op)};
    r.seld  = 4'((int'(inst) / 256) % 16);
    r.sela  = 4'((int'(inst) / 16) % 16);
    r.selb  = 4'(lo4);
    r.imme  = imm[15:0];
    r.regwe = we;
    return r;
  endfunction

  // One clock of stimulus: drive after the falling edge, push what the
  // registers must hold after the next rising edge.
  task automatic step(input logic rstn, input logic en, input logic [15:0] inst,
                      input bit use_exp, input out_t exp_val);
    out_t e;
    @(negedge I_CLK);
    I_RSTN = rstn;
    I_EN   = en;
    I_INST = inst;
    if (!rstn)    e = '0;
    else if (en)  e = use_exp ? exp_val : model(inst);
    else          e = model_state;
    model_state = e;
    exp_q.push_back(e);
  endtask

  task automatic direct_check(input string name, input out_t exp_val);
    out_t a;
    a = actual();
    n_checks++;
    if (a !== exp_val) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", name, a, exp_val);
    end
  endtask

  // Monitor: compares the registered outputs after every rising edge for
  // which the driver queued an expectation.
  initial begin
    out_t e;
    out_t a;
    forever begin
      @(posedge I_CLK);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = actual();
        n_checks++;
        if (a !== e) begin
          n_errors++;
          $display("FAIL out_check t=%0t: got aluop=%b sela=%h selb=%h seld=%h imme=%h regwe=%b required aluop=%b sela=%h selb=%h seld=%h imme=%h regwe=%b",
                   $time, a.aluop, a.sela, a.selb, a.seld, a.imme, a.regwe,
                   e.aluop, e.sela, e.selb, e.seld, e.imme, e.regwe);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  initial begin
`ifdef INST_DECODE_R0_PROTECT_EN
    r0_protect = 1'b1;
`else
    r0_protect = 1'b0;
`endif
    I_RSTN = 1'b0;
    I_EN   = 1'b1;
    I_INST = 16'hFFFF;
    #1;
    direct_check("reset_initial", '0);

    // Reset held across edges with an active-looking input.
    repeat (3) step(1'b0, 1'b1, 16'hFFFF, 1'b0, '0);
    // Enable low after reset: outputs stay cleared.
    repeat (2) step(1'b1, 1'b0, 16'hC707, 1'b0, '0);

    step(1'b1, 1'b1, 16'hC707, 1'b1, mk(5'b11100, 4'h7, 4'h0, 4'h7, 16'h0007, 1'b0));
    step(1'b1, 1'b1, 16'h1891, 1'b1, mk(5'b00001, 4'h8, 4'h9, 4'h1, 16'h0000, 1'b1));
    step(1'b1, 1'b1, 16'h93AB, 1'b1, mk(5'b11001, 4'h3, 4'hA, 4'hB, 16'hAB00, 1'b1));
    step(1'b1, 1'b1, 16'hA12E, 1'b1, mk(5'b11010, 4'h1, 4'h2, 4'hE, 16'hFFFE, 1'b1));
    step(1'b1, 1'b0, 16'h0012, 1'b0, '0);
    step(1'b1, 1'b1, 16'h0012, 1'b1, mk(5'b00000, 4'h0, 4'h1, 4'h2, 16'h0000, !r0_protect));
    step(1'b1, 1'b1, 16'h8280, 1'b1, mk(5'b11000, 4'h2, 4'h8, 4'h0, 16'h0080, 1'b1));
    step(1'b1, 1'b1, 16'hC580, 1'b1, mk(5'b11100, 4'h5, 4'h8, 4'h0, 16'hFF80, 1'b0));
    step(1'b1, 1'b1, 16'hA347, 1'b1, mk(5'b11010, 4'h3, 4'h4, 4'h7, 16'h0007, 1'b1));
    step(1'b1, 1'b1, 16'hE456, 1'b1, mk(5'b01110, 4'h4, 4'h5, 4'h6, 16'h0000, 1'b0));
    step(1'b1, 1'b1, 16'hB9AB, 1'b1, mk(5'b01011, 4'h9, 4'hA, 4'hB, 16'h0000, 1'b1));

    for (int i = 0; i < 400; i++) begin
      logic [15:0] inst;
      inst = 16'($urandom);
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0), inst, 1'b0, '0);
    end

    // Asynchronous reset in the middle of the high phase clears at once.
    step(1'b1, 1'b1, 16'h9FFF, 1'b0, '0);
    @(posedge I_CLK);
    #2;
    direct_check("pre_async_reset", mk(5'b11001, 4'hF, 4'hF, 4'hF, 16'hFF00, 1'b1));
    I_RSTN = 1'b0;
    #1;
    direct_check("async_reset", '0);
    step(1'b0, 1'b1, 16'h9FFF, 1'b0, '0);
    step(1'b1, 1'b1, 16'h5A3C, 1'b0, '0);

    repeat (2) @(posedge I_CLK);
    #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
